d_reg: RTL and testbench



---
 rtl/d_reg_pkg.sv | 5 +
 rtl/d_reg_bit.sv | 20 ++
 rtl/d_reg.sv | 34 +++
 tb/tb_d_reg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/d_reg_pkg.sv
// Shared defaults for the d_reg storage primitive and its users.
package d_reg_pkg;
    localparam int DREG_WIDTH = 1;
    localparam int DREG_DELAY = 24;
endpackage

// File: rtl/d_reg_bit.sv
// One-bit D flip-flop cell with async active-low clear to INIT.
// Latency: capture on Clk rise; no backpressure.
module d_reg_bit #(
    parameter logic INIT = 1'b0
) (
    output logic Q,
    input  logic D,
    input  logic nReset,
    input  logic Clk
);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Q <= INIT;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/d_reg.sv
// WIDTH-bit positive-edge D register with complementary outputs and async active-low clear.
// Latency: Q/nQ update on the capturing Clk edge; no enable, gate Clk externally.
module d_reg
    import d_reg_pkg::*;
#(
    parameter int              WIDTH = DREG_WIDTH,
    parameter int              DELAY = DREG_DELAY,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    input  logic [WIDTH-1:0] D,
    input  logic             nReset,
    input  logic             Clk
);

    // DELAY describes output settling for timing-annotated models only; it adds no hardware.
    if (DELAY < 0) begin : g_negative_delay_unsupported
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_reg_bit #(
            .INIT (INIT[i])
        ) u_bit (
            .Q      (Q[i]),
            .D      (D[i]),
            .nReset (nReset),
            .Clk    (Clk)
        );
    end

    assign nQ = ~Q;

endmodule

// File: tb/tb_d_reg.sv
// Self-checking bench for d_reg: reset, capture, async clear, toggle, ripple counter, wide INIT.
module tb_d_reg;

    logic       clk;
    logic       nrst_a, nrst_b, clear_counter, en;
    logic [7:0] d_a, q_a, nq_a;
    logic       d_b_drv, tie_b, d_b, q_b, nq_b;
    logic [3:0] pc, npc;
    logic       gclk, nrst_c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_a;
    logic       exp_b;
    int         ticks;

    d_reg #(.WIDTH(8), .DELAY(24), .INIT(8'hA5)) u_a (
        .Q(q_a), .nQ(nq_a), .D(d_a), .nReset(nrst_a), .Clk(clk)
    );

    assign d_b = tie_b ? nq_b : d_b_drv;
    d_reg #(.WIDTH(1), .DELAY(24), .INIT(1'b0)) u_b (
        .Q(q_b), .nQ(nq_b), .D(d_b), .nReset(nrst_b), .Clk(clk)
    );

    // Ripple counter: gated clock drives stage 0, each later stage clocks from the previous Q.
    assign gclk   = en & clk;
    assign nrst_c = ~clear_counter;
    d_reg #(.WIDTH(1), .DELAY(24), .INIT(1'b0)) u_s0 (
        .Q(pc[0]), .nQ(npc[0]), .D(npc[0]), .nReset(nrst_c), .Clk(gclk)
    );
    for (genvar k = 1; k < 4; k++) begin : g_stage
        d_reg #(.WIDTH(1), .DELAY(24), .INIT(1'b0)) u_s (
            .Q(pc[k]), .nQ(npc[k]), .D(npc[k]), .nReset(nrst_c), .Clk(pc[k-1])
        );
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic rise();
        clk = 1'b1;
        #4;
    endtask

    task automatic fall();
        clk = 1'b0;
        #4;
    endtask

    task automatic tick();
        rise();
        fall();
    endtask

    initial begin
        clk = 0; nrst_a = 1; nrst_b = 1; clear_counter = 0; en = 0;
        d_a = 8'h00; d_b_drv = 1'b1; tie_b = 0;
        #1;
        nrst_a = 0; nrst_b = 0; clear_counter = 1;
        #1;
        check("rst_q_a",  q_a,  8'hA5);
        check("rst_nq_a", nq_a, 8'h5A);
        check("rst_q_b",  {7'd0, q_b},  8'h00);
        check("rst_nq_b", {7'd0, nq_b}, 8'h01);

        // Clock edges during reset are ignored.
        d_a = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_q_b", {7'd0, q_b}, 8'h00);
            check("rst_hold_q_a", q_a, 8'hA5);
        end

        // Release between edges; the first rising edge captures.
        nrst_b = 1; #2;
        check("post_release_q_b", {7'd0, q_b}, 8'h00);
        rise();
        check("first_cap_q_b",  {7'd0, q_b},  8'h01);
        check("first_cap_nq_b", {7'd0, nq_b}, 8'h00);
        fall();

        // Directed capture sequence; falling edges must not change anything.
        for (int i = 0; i < 4; i++) begin
            exp_b = (i == 1) ? 1'b0 : 1'b1;
            d_b_drv = exp_b;
            rise();
            check("cap_q_b", {7'd0, q_b}, {7'd0, exp_b});
            d_b_drv = ~exp_b;
            fall();
            check("cap_fall_q_b",  {7'd0, q_b},  {7'd0, exp_b});
            check("cap_fall_nq_b", {7'd0, nq_b}, {7'd0, ~exp_b});
        end

        // Wide register: fixed 3C then randomized data against the model.
        nrst_a = 1; #1;
        exp_a = 8'hA5;
        d_a = 8'h3C;
        tick();
        exp_a = 8'h3C;
        check("wide_q_3c",  q_a,  8'h3C);
        check("wide_nq_c3", nq_a, 8'hC3);
        for (int i = 0; i < 24; i++) begin
            d_a = 8'($urandom);
            rise();
            exp_a = d_a;
            d_a = 8'($urandom);
            fall();
            check("rand_q_a",  q_a,  exp_a);
            check("rand_nq_a", nq_a, ~exp_a);
        end

        // Asynchronous clear in mid-cycle, no clock edge involved.
        d_a = 8'hFF;
        tick();
        check("pre_clear_q_a", q_a, 8'hFF);
        rise();
        nrst_a = 0; #1;
        check("async_clear_q_a",  q_a,  8'hA5);
        check("async_clear_nq_a", nq_a, 8'h5A);
        fall();
        nrst_a = 1; #1;

        // Reset asserted together with a Clk rise: reset wins.
        d_a = 8'h3C;
        tick();
        check("recover_q_a", q_a, 8'h3C);
        d_a = 8'h77;
        clk = 1; nrst_a = 0;
        #2;
        check("coincident_q_a", q_a, 8'hA5);
        fall();
        nrst_a = 1; #1;

        // Toggle: D fed from nQ after a fresh reset.
        nrst_b = 0; #1;
        check("toggle_rst_q_b", {7'd0, q_b}, 8'h00);
        nrst_b = 1; tie_b = 1; #1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("toggle_q_b", {7'd0, q_b}, 8'((i % 2)));
        end

        // Ripple counter: counts down by one per gated clock, wrapping after 16.
        clear_counter = 0; #1;
        check("ripple_start", {4'd0, pc}, 8'h00);
        en = 1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("ripple_pc", {4'd0, pc}, 8'((16 - n) % 16));
        end
        en = 0;
        tick();
        check("ripple_gated", {4'd0, pc}, 8'h00);
        en = 1;
        ticks = 3 + int'($urandom_range(0, 9));
        for (int n = 0; n < ticks; n++) tick();
        check("ripple_mid", {4'd0, pc}, 8'((16 - ticks) % 16));
        clear_counter = 1; #1;
        check("ripple_clear", {4'd0, pc}, 8'h00);
        tick();
        check("ripple_clear_hold", {4'd0, pc}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
